// File: rtl/inst_fetch_resp.sv
// Instruction fetch response stage: issues one bus request per fetch and returns
// the instruction with a one-cycle valid. Optional alignment check: IF_ALIGN_CHECK_EN.
module inst_fetch_resp #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        stall_hold,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        stallreq,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic        misalign_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_err_q, misalign_err_d;
    logic        drop_q, drop_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_data_q, pend_data_d;

    logic        ack_v;
    logic        timeout;
    logic [7:0]  cnt_inc;

    assign ack_v    = mem_ack & mem_req_q;
    assign timeout  = ({1'b0, cnt_q} + 9'd1) >= TO_LIM;
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign stallreq = (state_q == WAIT) & ~ack_v;

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        inst_d         = inst_q;
        inst_valid_d   = stall_hold ? inst_valid_q : 1'b0;
        bus_err_d      = 1'b0;
        misalign_err_d = 1'b0;
        drop_d         = drop_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        pend_data_d    = pend_data_q;

        // Data acked during a downstream stall is released on the first free cycle.
        if (pend_q && !stall_hold) begin
            inst_d       = pend_data_q;
            inst_valid_d = 1'b1;
            pend_d       = 1'b0;
        end

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (flush) begin
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b0;
                    pend_d       = 1'b0;
                end else if (ce && !stall_hold) begin
`ifdef IF_ALIGN_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        misalign_err_d = 1'b1;
                        inst_d         = NOP_INST;
                        inst_valid_d   = 1'b0;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc;
                        cnt_d      = 8'd0;
                        state_d    = WAIT;
                    end
`else
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc[31:2], 2'b00};
                    cnt_d      = 8'd0;
                    state_d    = WAIT;
`endif
                end
            end
            WAIT: begin
                if (flush) begin
                    drop_d = 1'b1;
                    pend_d = 1'b0;
                end
                if (ack_v) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    drop_d    = 1'b0;
                    if (drop_q || flush) begin
                        if (!stall_hold) begin
                            inst_d       = NOP_INST;
                            inst_valid_d = 1'b0;
                        end
                    end else if (stall_hold) begin
                        pend_d      = 1'b1;
                        pend_data_d = mem_rdata;
                    end else begin
                        inst_d       = mem_rdata;
                        inst_valid_d = 1'b1;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    drop_d    = 1'b0;
                    cnt_d     = cnt_inc;
                    if (!stall_hold) begin
                        inst_d       = NOP_INST;
                        inst_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= 32'd0;
            inst_q         <= NOP_INST;
            inst_valid_q   <= 1'b0;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
            drop_q         <= 1'b0;
            cnt_q          <= 8'd0;
            pend_q         <= 1'b0;
            pend_data_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            inst_q         <= inst_d;
            inst_valid_q   <= inst_valid_d;
            bus_err_q      <= bus_err_d;
            misalign_err_q <= misalign_err_d;
            drop_q         <= drop_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            pend_data_q    <= pend_data_d;
        end
    end

    assign inst         = inst_q;
    assign inst_valid   = inst_valid_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign bus_err      = bus_err_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp (TIMEOUT=8); inputs change 1ns after the rising edge.
module tb_inst_fetch_resp;

    logic        clk = 1'b0;
    logic        rst, ce, flush, stall_hold, mem_ack;
    logic [31:0] pc, mem_rdata;
    logic [31:0] inst, mem_addr;
    logic        inst_valid, stallreq, mem_req, bus_err, misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch_resp #(.TIMEOUT(8), .NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush), .stall_hold(stall_hold),
        .inst(inst), .inst_valid(inst_valid), .stallreq(stallreq),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; pc = 32'd0; flush = 1'b0; stall_hold = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, inst, inst_valid, bus_err, misalign_err, stallreq} !==
            {1'b0, 32'd0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: req=%b addr=%h inst=%h v=%b be=%b me=%b sr=%b",
                     mem_req, mem_addr, inst, inst_valid, bus_err, misalign_err, stallreq);
        end
    endtask

    task automatic test_basic();
        int sr_seen = 0;
        ce = 1'b1; pc = 32'h3000_0000;
        #1; if (stallreq) sr_seen++;
        step();
        ce = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0010_0093;
        #1; if (stallreq) sr_seen++;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h3000_0000) begin
            errors++; $display("FAIL basic_req: req=%b addr=%h want 1 30000000", mem_req, mem_addr);
        end
        step();
        mem_ack = 1'b0;
        #1; if (stallreq) sr_seen++;
        checks++;
        if (inst !== 32'h0010_0093 || inst_valid !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL basic_inst: inst=%h v=%b req=%b want 00100093 1 0", inst, inst_valid, mem_req);
        end
        step();
        checks++;
        if (inst_valid !== 1'b0 || sr_seen != 0) begin
            errors++; $display("FAIL basic_pulse: v=%b stallreq_cycles=%0d want 0 0", inst_valid, sr_seen);
        end
    endtask

    task automatic test_delayed();
        int vcnt = 0;
        int sr_cnt = 0;
        int addr_bad = 0;
        ce = 1'b1; pc = 32'h3000_0004;
        step();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stallreq) sr_cnt++;
            if (mem_addr !== 32'h3000_0004 || mem_req !== 1'b1) addr_bad++;
            step();
            if (inst_valid) vcnt++;
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        if (stallreq) sr_cnt++;
        step();
        mem_ack = 1'b0;
        if (inst_valid) vcnt++;
        checks++;
        if (inst !== 32'h1234_5678) begin
            errors++; $display("FAIL delayed_inst: inst=%h want 12345678", inst);
        end
        step();
        if (inst_valid) vcnt++;
        checks++;
        if (sr_cnt != 3) begin
            errors++; $display("FAIL delayed_stallreq: cycles=%0d want 3", sr_cnt);
        end
        checks++;
        if (addr_bad != 0) begin
            errors++; $display("FAIL delayed_addr: unstable cycles=%0d want 0", addr_bad);
        end
        checks++;
        if (vcnt != 1) begin
            errors++; $display("FAIL delayed_valid: pulses=%0d want 1", vcnt);
        end
    endtask

    task automatic test_flush();
        int vcnt = 0;
        ce = 1'b1; pc = 32'h3000_0008;
        step();
        ce = 1'b0;
        step();                                   // WAIT 1
        flush = 1'b1;
        step();                                   // WAIT 2 (flush)
        flush = 1'b0;
        if (inst_valid) vcnt++;
        step();                                   // WAIT 3
        if (inst_valid) vcnt++;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();                                   // WAIT 4 (ack)
        mem_ack = 1'b0;
        if (inst_valid) vcnt++;
        checks++;
        if (inst !== 32'h0000_0013 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_inst: inst=%h req=%b want 00000013 0", inst, mem_req);
        end
        step();
        if (inst_valid) vcnt++;
        checks++;
        if (vcnt != 0) begin
            errors++; $display("FAIL flush_valid: pulses=%0d want 0", vcnt);
        end
        ce = 1'b1; pc = 32'h3000_0020;
        step();
        ce = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h3000_0020) begin
            errors++; $display("FAIL flush_restart: req=%b addr=%h want 1 30000020", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
        step();
        mem_ack = 1'b0;
        checks++;
        if (inst !== 32'h0000_1111 || inst_valid !== 1'b1) begin
            errors++; $display("FAIL flush_next_inst: inst=%h v=%b want 00001111 1", inst, inst_valid);
        end
        step();
    endtask

    task automatic test_timeout();
        int early = 0;
        ce = 1'b1; pc = 32'h3000_000C;
        step();
        ce = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            if (bus_err || !mem_req) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL timeout_early: bad cycles=%0d want 0", early);
        end
        step();                                   // 8th WAIT cycle ends
        checks++;
        if (bus_err !== 1'b1 || mem_req !== 1'b0 || inst !== 32'h0000_0013 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_err: be=%b req=%b inst=%h v=%b want 1 0 00000013 0",
                               bus_err, mem_req, inst, inst_valid);
        end
        step();
        checks++;
        if (bus_err !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: be=%b want 0", bus_err);
        end
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_0BAD;
        step();
        mem_ack = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0000_0013 || mem_req !== 1'b0 || stallreq !== 1'b0) begin
            errors++; $display("FAIL timeout_late_ack: v=%b inst=%h req=%b sr=%b want 0 00000013 0 0",
                               inst_valid, inst, mem_req, stallreq);
        end
    endtask

    task automatic test_stall_hold();
        ce = 1'b1; pc = 32'h3000_0010;
        step();
        ce = 1'b0; stall_hold = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        step();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0000_0013) begin
            errors++; $display("FAIL stall_ack: req=%b v=%b inst=%h want 0 0 00000013", mem_req, inst_valid, inst);
        end
        step();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL stall_hold: v=%b want 0", inst_valid);
        end
        stall_hold = 1'b0;
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001) begin
            errors++; $display("FAIL stall_release: v=%b inst=%h want 1 cafe0001", inst_valid, inst);
        end
        step();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL stall_pulse: v=%b want 0", inst_valid);
        end
    endtask

    task automatic test_idle_flush();
        flush = 1'b1; ce = 1'b1; pc = 32'h3000_0030;
        step();
        flush = 1'b0; ce = 1'b0;
        checks++;
        if (inst !== 32'h0000_0013 || inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL idle_flush: inst=%h v=%b req=%b want 00000013 0 0", inst, inst_valid, mem_req);
        end
    endtask

    task automatic test_align();
        ce = 1'b1; pc = 32'h3000_0002;
        step();
        ce = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        checks++;
        if (misalign_err !== 1'b1 || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL align_err: me=%b req=%b v=%b want 1 0 0", misalign_err, mem_req, inst_valid);
        end
        step();
        checks++;
        if (misalign_err !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL align_pulse: me=%b req=%b want 0 0", misalign_err, mem_req);
        end
`else
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h3000_0000 || misalign_err !== 1'b0) begin
            errors++; $display("FAIL align_addr: req=%b addr=%h me=%b want 1 30000000 0", mem_req, mem_addr, misalign_err);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_2222;
        step();
        mem_ack = 1'b0;
        step();
`endif
    endtask

    task automatic test_reset_in_wait();
        ce = 1'b1; pc = 32'h3000_0040;
        step();
        ce = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        checks++;
        if (stallreq !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rst_wait: sr=%b req=%b want 0 0", stallreq, mem_req);
        end
        step();
        mem_ack = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0000_0013) begin
            errors++; $display("FAIL rst_wait_ack: v=%b inst=%h want 0 00000013", inst_valid, inst);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed();
        test_flush();
        test_timeout();
        test_stall_hold();
        test_idle_flush();
        test_align();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_resp.md
INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum wait cycles for mem_ack (8-bit counter).
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013, the instruction value presented when no valid fetch exists.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port ce, input, 1, fetch enable from the PC stage.
REQ-006 The block SHALL have port pc, input, 32, fetch address from the PC stage.
REQ-007 The block SHALL have port flush, input, 1, pipeline flush that discards any fetch in progress.
REQ-008 The block SHALL have port stall_hold, input, 1, downstream stall; while high, the block holds its outputs and starts no new request.
REQ-009 The block SHALL have port inst, output, 32, the fetched instruction.
REQ-010 The block SHALL have port inst_valid, output, 1, one-cycle qualifier for inst.
REQ-011 The block SHALL have port stallreq, output, 1, asks the pipeline to freeze pc.
REQ-012 The block SHALL have ports mem_req (output, 1), mem_addr (output, 32), mem_ack (input, 1) and mem_rdata (input, 32), forming the backing instruction bus.
REQ-013 The block SHALL have port bus_err, output, 1, a one-cycle pulse on timeout.
REQ-014 The block SHALL have port misalign_err, output, 1, a one-cycle pulse on a misaligned pc.

Function
REQ-015 The block SHALL implement states IDLE and WAIT.
REQ-016 In IDLE with ce=1, flush=0 and stall_hold=0, the block SHALL register mem_req<=1 and mem_addr<=pc, clear the timeout counter, and go to WAIT.
REQ-017 In WAIT, mem_req and mem_addr SHALL stay stable until mem_ack is sampled high.
REQ-018 mem_ack SHALL be ignored while mem_req=0.
REQ-019 On mem_ack in WAIT, the block SHALL set mem_req<=0 and return to IDLE; if no drop is pending, it SHALL set inst<=mem_rdata and inst_valid<=1 for exactly one cycle.
REQ-020 Minimum latency from ce sampled high to inst_valid SHALL be 2 cycles, with mem_ack high in the first WAIT cycle.
REQ-021 stallreq SHALL be combinational and equal 1 in WAIT, except in the cycle mem_ack=1.
REQ-022 flush in WAIT SHALL set a drop flag; the bus transfer SHALL still complete, and on its mem_ack inst SHALL become NOP_INST with inst_valid=0.
REQ-023 flush in IDLE SHALL set inst<=NOP_INST and inst_valid<=0, and SHALL start no request that cycle.
REQ-024 flush and mem_ack in the same WAIT cycle SHALL discard the data.
REQ-025 The drop flag SHALL clear on leaving WAIT.
REQ-026 While stall_hold=1, inst and inst_valid SHALL hold their values; a WAIT transfer in progress SHALL continue.
REQ-027 If an ack arrives while stall_hold=1, its data SHALL be latched, and inst_valid SHALL assert in the first cycle stall_hold=0.
REQ-028 The timeout counter SHALL increment each WAIT cycle without ack; on reaching TIMEOUT, the block SHALL pulse bus_err, drop mem_req, present NOP_INST with inst_valid=0, and go to IDLE.
REQ-029 A late mem_ack after a timeout SHALL be ignored.
REQ-030 The timeout counter SHALL saturate and never wrap.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL enter IDLE and set mem_req=0, mem_addr=0, inst=NOP_INST, inst_valid=0, bus_err=0, misalign_err=0, drop=0 and counter=0.
REQ-032 Reset in WAIT SHALL abandon the transfer; any ack in following cycles SHALL be ignored (REQ-018).
REQ-033 stallreq SHALL be 0 in the cycle after reset.

Configuration
REQ-034 With IF_ALIGN_CHECK_EN defined, a start condition in IDLE with pc[1:0]!=2'b00 SHALL issue no request, pulse misalign_err for one cycle, set inst=NOP_INST and inst_valid=0, and stay in IDLE.
REQ-035 Without IF_ALIGN_CHECK_EN, mem_addr SHALL be {pc[31:2],2'b00} and misalign_err SHALL be tied 0.

Verification
REQ-036 The bench SHALL cover: reset, then ce=1, pc=32'h3000_0000, with mem_ack in the first WAIT cycle and rdata=32'h0010_0093 -> inst=32'h0010_0093 and inst_valid=1 two cycles after ce, and stallreq=0 throughout.
REQ-037 The bench SHALL cover: mem_ack delayed 3 cycles -> stallreq=1 for 3 cycles, mem_addr stable at 32'h3000_0004, and a single inst_valid pulse.
REQ-038 The bench SHALL cover: flush in the 2nd WAIT cycle, ack in the 4th with rdata=32'hDEAD_BEEF -> inst=32'h0000_0013, inst_valid never 1, and the next ce starts a new request.
REQ-039 The bench SHALL cover: no ack with TIMEOUT=8 -> bus_err pulse after 8 WAIT cycles, mem_req=0, and an ack on cycle 10 ignored.
REQ-040 The bench SHALL cover: stall_hold=1 across an ack -> inst_valid delayed until stall_hold falls, and inst equals the acked data.
REQ-041 The bench SHALL cover: with IF_ALIGN_CHECK_EN, pc=32'h3000_0002 -> misalign_err=1 for one cycle and mem_req stays 0; without the macro -> mem_addr=32'h3000_0000.
